// File: rtl/alu_pkg.sv
// Shared types for the ALU and its iterative multiply/divide unit.
package alu_pkg;

  typedef enum logic [3:0] {
    OpAnd   = 4'd0,
    OpOr    = 4'd1,
    OpAdd   = 4'd2,
    OpSll   = 4'd3,
    OpSrl   = 4'd4,
    OpEq    = 4'd5,
    OpSub   = 4'd6,
    OpSlt   = 4'd7,
    OpSltu  = 4'd8,
    OpSra   = 4'd9,
    OpMultu = 4'd10,
    OpDivu  = 4'd11,
    OpNor   = 4'd12,
    OpXor   = 4'd13,
    OpMfhi  = 4'd14,
    OpMflo  = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDiv,
    StDone
  } mdu_state_e;

endpackage

// File: rtl/mdu_seq.sv
// Iterative unsigned multiply (shift-add) and divide (restoring), one bit per cycle,
// owning the HI/LO registers.
module mdu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(WIDTH);

  mdu_state_e         state_q;
  logic [2*WIDTH-1:0] acc_q, acc_step;
  logic [WIDTH-1:0]   opnd_q, hi_q, lo_q;
  logic [CntW-1:0]    cnt_q;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;

  // acc_q holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    if (state_q == StMul) begin
      acc_step = {mul_sum, acc_q[WIDTH-1:1]};
    end else if (div_diff[WIDTH]) begin
      acc_step = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      // A zero divisor never borrows, so the quotient fills with ones and the remainder ends as A.
      acc_step = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      opnd_q  <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          cnt_q <= '0;
          if (start && op == OpMultu) begin
            state_q <= StMul;
            acc_q   <= {{WIDTH{1'b0}}, b};
            opnd_q  <= a;
          end else if (start && op == OpDivu) begin
            state_q <= StDiv;
            acc_q   <= {{WIDTH{1'b0}}, a};
            opnd_q  <= b;
          end else begin
            state_q <= StIdle;
          end
        end
        StMul, StDiv: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CntW'(WIDTH - 1)) begin
            state_q <= StDone;
            hi_q    <= acc_step[2*WIDTH-1:WIDTH];
            lo_q    <= acc_step[WIDTH-1:0];
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = (state_q == StMul) || (state_q == StDiv);
  assign done = (state_q == StDone);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: rtl/alu_mdu.sv
// Single-cycle ALU with an attached iterative multiply/divide unit and HI/LO readback.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [WIDTH-1:0]   i_data_A,
  input  logic [WIDTH-1:0]   i_data_B,
  input  logic [SHAMT_W-1:0] i_data_shamt,
  input  logic [3:0]         i_con_AluCtrl,
  input  logic               i_con_Start,
  output logic [WIDTH-1:0]   o_data_AluRes,
  output logic               o_con_Zero,
  output logic               o_con_Busy,
  output logic               o_con_Done,
  output logic [WIDTH-1:0]   o_data_Hi,
  output logic [WIDTH-1:0]   o_data_Lo
);

  alu_op_e          op;
  logic [WIDTH-1:0] hi, lo, res;

  assign op = alu_op_e'(i_con_AluCtrl);

  mdu_seq #(
    .WIDTH(WIDTH)
  ) u_mdu_seq (
    .clk  (i_clk),
    .rst  (i_rst),
    .start(i_con_Start),
    .op   (op),
    .a    (i_data_A),
    .b    (i_data_B),
    .busy (o_con_Busy),
    .done (o_con_Done),
    .hi   (hi),
    .lo   (lo)
  );

  always_comb begin
    res = '0;
    unique case (op)
      OpAnd:   res = i_data_A & i_data_B;
      OpOr:    res = i_data_A | i_data_B;
      OpAdd:   res = i_data_A + i_data_B;
      OpSll:   res = i_data_B << i_data_shamt;
      OpSrl:   res = i_data_B >> i_data_shamt;
      OpEq:    res = {{(WIDTH-1){1'b0}}, i_data_A == i_data_B};
      OpSub:   res = i_data_A - i_data_B;
      OpSlt:   res = {{(WIDTH-1){1'b0}}, $signed(i_data_A) < $signed(i_data_B)};
      OpSltu:  res = {{(WIDTH-1){1'b0}}, i_data_A < i_data_B};
      OpSra:   res = $signed(i_data_B) >>> i_data_shamt;
      OpMultu: res = '0;
      OpDivu:  res = '0;
      OpNor:   res = ~(i_data_A | i_data_B);
      OpXor:   res = i_data_A ^ i_data_B;
      OpMfhi:  res = hi;
      OpMflo:  res = lo;
      default: res = '0;
    endcase
  end

  assign o_data_AluRes = res;
  assign o_con_Zero    = (res == '0);
  assign o_data_Hi     = hi;
  assign o_data_Lo     = lo;

endmodule

// File: tb/tb_alu_mdu.sv
// Randomised self-checking bench for alu_mdu against a plain-arithmetic reference model.
module tb_alu_mdu;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b;
  logic [4:0]  sh;
  logic [3:0]  ctrl;
  logic        start;
  logic [31:0] res, hi, lo;
  logic        zero, busy, done;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] m_hi, m_lo;

  alu_mdu #(
    .WIDTH(32)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_data_A     (a),
    .i_data_B     (b),
    .i_data_shamt (sh),
    .i_con_AluCtrl(ctrl),
    .i_con_Start  (start),
    .o_data_AluRes(res),
    .o_con_Zero   (zero),
    .o_con_Busy   (busy),
    .o_con_Done   (done),
    .o_data_Hi    (hi),
    .o_data_Lo    (lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] x, y,
                                          input logic [4:0] s);
    case (op)
      0:  return x & y;
      1:  return x | y;
      2:  return x + y;
      3:  return y << s;
      4:  return y >> s;
      5:  return (x == y) ? 32'd1 : 32'd0;
      6:  return x - y;
      7:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      8:  return (x < y) ? 32'd1 : 32'd0;
      9:  return (y >> s) | (y[31] ? ~(32'hFFFF_FFFF >> s) : 32'd0);
      12: return ~(x | y);
      13: return x ^ y;
      14: return m_hi;
      15: return m_lo;
      default: return 32'd0;
    endcase
  endfunction

  task automatic test_reset;
    logic [31:0] e;
    rst = 1'b1; start = 1'b0; ctrl = 4'd2; a = 32'd0; b = 32'd0; sh = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++; $display("FAIL reset_flags busy/done=%b required 00", {busy, done});
    end
    checks++;
    if (hi !== 32'd0 || lo !== 32'd0) begin
      errors++; $display("FAIL reset_hilo hi=%h lo=%h required 0/0", hi, lo);
    end
    ctrl = 4'd14; #1;
    checks++;
    if (res !== 32'd0 || zero !== 1'b1) begin
      errors++; $display("FAIL reset_mfhi res=%h zero=%b required 0/1", res, zero);
    end
    ctrl = 4'd2; a = $urandom; b = $urandom; #1;
    e = a + b;
    checks++;
    if (res !== e) begin
      errors++; $display("FAIL reset_add_follows res=%h required %h", res, e);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
  endtask

  task automatic test_comb_directed;
    logic [3:0]  t_op[4] = '{4'd6, 4'd9, 4'd7, 4'd8};
    logic [31:0] t_a[4]  = '{32'd5, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] t_b[4]  = '{32'd5, 32'h8000_0000, 32'd1, 32'd1};
    logic [4:0]  t_s[4]  = '{5'd0, 5'd4, 5'd0, 5'd0};
    logic [31:0] t_e[4]  = '{32'd0, 32'hF800_0000, 32'd1, 32'd0};
    for (int i = 0; i < 4; i++) begin
      ctrl = t_op[i]; a = t_a[i]; b = t_b[i]; sh = t_s[i]; #1;
      checks++;
      if (res !== t_e[i] || zero !== (t_e[i] == 32'd0)) begin
        errors++;
        $display("FAIL directed_%0d op=%0d res=%h zero=%b required %h/%b", i, t_op[i], res,
                 zero, t_e[i], t_e[i] == 32'd0);
      end
    end
  endtask

  task automatic test_comb_random;
    logic [31:0] e;
    start = 1'b0;
    for (int i = 0; i < 300; i++) begin
      ctrl = 4'($urandom_range(0, 15)); a = $urandom; b = $urandom; sh = 5'($urandom);
      if (i % 7 == 0) b = a;
      #1;
      e = ref_alu(int'(ctrl), a, b, sh);
      checks++;
      if (res !== e || zero !== (e == 32'd0)) begin
        errors++;
        $display("FAIL comb_random op=%0d a=%h b=%h sh=%0d res=%h zero=%b required %h/%b",
                 ctrl, a, b, sh, res, zero, e, e == 32'd0);
      end
    end
  endtask

  // Called one time unit after a rising edge; returns at the same phase of the Done cycle.
  task automatic mdu_op(input logic [3:0] op, input logic [31:0] x, y, input int inject,
                        output int done_cyc);
    logic [63:0] e;
    if (op == 4'd10)      e = {32'd0, x} * {32'd0, y};
    else if (y == 32'd0)  e = {x, 32'hFFFF_FFFF};
    else                  e = {x % y, x / y};
    ctrl = op; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; ctrl = 4'd15; a = $urandom; b = $urandom;
    #1;
    for (int c = 1; c <= 32; c++) begin
      checks++;
      if ({busy, done} !== 2'b10) begin
        errors++; $display("FAIL busy_window cycle=%0d busy/done=%b required 10", c, {busy, done});
      end
      if (ctrl == 4'd15) begin
        checks++;
        if (res !== m_lo) begin
          errors++; $display("FAIL mflo_while_busy cycle=%0d res=%h required %h", c, res, m_lo);
        end
      end
      if (c == inject) begin
        ctrl = 4'd11; start = 1'b1; a = 32'd9; b = 32'd0;
      end else begin
        ctrl = 4'd15; start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0; ctrl = 4'd15; #1;
    done_cyc = cyc;
    checks++;
    if ({busy, done} !== 2'b01) begin
      errors++; $display("FAIL done_cycle op=%0d busy/done=%b required 01", op, {busy, done});
    end
    checks++;
    if ({hi, lo} !== e || res !== e[31:0]) begin
      errors++;
      $display("FAIL result op=%0d a=%h b=%h hi:lo=%h mflo=%h required %h", op, x, y,
               {hi, lo}, res, e);
    end
    m_hi = e[63:32]; m_lo = e[31:0];
  endtask

  task automatic step_expect_idle(input string name);
    @(posedge clk); #1;
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++; $display("FAIL %s busy/done=%b required 00", name, {busy, done});
    end
  endtask

  task automatic test_mul_div;
    int d;
    mdu_op(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, d);
    step_expect_idle("mul_done_pulse");
    mdu_op(4'd11, 32'd100, 32'd7, 0, d);
    step_expect_idle("div_done_pulse");
    mdu_op(4'd11, 32'd9, 32'd0, 0, d);
    step_expect_idle("div0_done_pulse");
    for (int i = 0; i < 6; i++) begin
      mdu_op((i % 2 == 0) ? 4'd10 : 4'd11, $urandom, (i == 3) ? 32'd0 : $urandom >> (i * 4),
             0, d);
      step_expect_idle("rand_done_pulse");
    end
  endtask

  task automatic test_busy_ignore;
    int d;
    mdu_op(4'd10, 32'd3, 32'd4, 10, d);
    step_expect_idle("ignored_start");
  endtask

  task automatic test_back_to_back;
    int d1, d2;
    mdu_op(4'd10, $urandom, $urandom, 0, d1);
    mdu_op(4'd11, $urandom, $urandom >> 8, 0, d2);
    checks++;
    if (d2 - d1 !== 33) begin
      errors++; $display("FAIL back_to_back spacing=%0d required 33", d2 - d1);
    end
    step_expect_idle("b2b_done_pulse");
  endtask

  task automatic test_reset_mid;
    int d;
    int seen;
    ctrl = 4'd11; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({busy, done} !== 2'b00 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid busy/done=%b hi=%h lo=%h required 00/0/0", {busy, done}, hi, lo);
    end
    ctrl = 4'd15; #1;
    checks++;
    if (res !== 32'd0) begin
      errors++; $display("FAIL reset_mid_mflo res=%h required 0", res);
    end
    rst = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL reset_abort activity_cycles=%0d required 0", seen);
    end
    mdu_op(4'd10, 32'd2, 32'd3, 0, d);
    step_expect_idle("post_reset_done_pulse");
  endtask

  initial begin
    test_reset();
    test_comb_directed();
    test_comb_random();
    test_mul_div();
    test_comb_random();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 Parameter WIDTH, default 32: datapath width in bits; legal values 8, 16, 32, 64.
REQ-002 Parameter SHAMT_W, default $clog2(WIDTH): shift-amount width, derived from WIDTH and never overridden.
REQ-003 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 i_rst  input  1  synchronous, active-high reset.
REQ-005 i_data_A  input  WIDTH  operand A (rs).
REQ-006 i_data_B  input  WIDTH  operand B (rt/immediate).
REQ-007 i_data_shamt  input  SHAMT_W  shift amount.
REQ-008 i_con_AluCtrl  input  4  operation select.
REQ-009 i_con_Start  input  1  launches a multiply/divide when AluCtrl is MULTU or DIVU.
REQ-010 o_data_AluRes  output  WIDTH  combinational result.
REQ-011 o_con_Zero  output  1  high when o_data_AluRes == 0.
REQ-012 o_con_Busy  output  1  multiply/divide in progress.
REQ-013 o_con_Done  output  1  one-cycle pulse when a multiply/divide completes.
REQ-014 o_data_Hi / o_data_Lo  output  WIDTH each  HI/LO architectural registers.

Function
REQ-015 Ops 0 AND, 1 OR, 2 ADD, 3 SLL (B<<shamt), 4 SRL, 5 EQ (A==B ? 1:0), 6 SUB, 7 SLT signed, 8 SLTU, 9 SRA (arithmetic B>>shamt), 12 NOR, 13 XOR, 14 MFHI (=Hi), 15 MFLO (=Lo) SHALL be combinational with zero latency.
REQ-016 ADD/SUB SHALL wrap modulo 2^WIDTH with no overflow flag; SLT/EQ results are zero-extended to WIDTH.
REQ-017 o_con_Zero SHALL be computed from the final o_data_AluRes in the same cycle, for every op.
REQ-018 Ops 10 MULTU and 11 DIVU SHALL drive o_data_AluRes = 0 and act only through i_con_Start.
REQ-019 FSM states IDLE, MUL, DIV, DONE; IDLE->MUL on Start&&op==10, IDLE->DIV on Start&&op==11; other Start values are ignored.
REQ-020 At the accepting edge, A and B SHALL be captured; later operand changes have no effect.
REQ-021 MUL and DIV SHALL each last exactly WIDTH cycles (one bit per cycle: shift-add multiply, restoring divide), then move to DONE.
REQ-022 o_con_Busy SHALL be high exactly while in MUL or DIV; o_con_Done SHALL be high exactly while in DONE, which lasts one cycle.
REQ-023 Hi/Lo SHALL update on the edge entering DONE: MULTU Hi:Lo = 2*WIDTH-bit unsigned product; DIVU Lo = quotient, Hi = remainder.
REQ-024 Divide by zero: Lo = all ones, Hi = A, with the same latency and no error flag.
REQ-025 Start while Busy SHALL be ignored; Start in DONE SHALL be accepted (DONE->MUL/DIV) with no bubble.
REQ-026 MFHI/MFLO while Busy SHALL return the previous Hi/Lo values.
REQ-027 From accepting edge at cycle 0, Done and the new Hi/Lo SHALL be visible in cycle WIDTH+1.

Reset
REQ-028 While i_rst is high at an edge: state to IDLE, Hi = Lo = 0, Busy = Done = 0, captured operands cleared.
REQ-029 Reset mid-operation SHALL abort the op with no Done pulse; Hi/Lo read 0 in the following cycle.
REQ-030 Combinational outputs (AluRes, Zero) SHALL keep following inputs during reset; MFHI/MFLO return 0.

Structure
REQ-031 Package alu_pkg SHALL hold the 4-bit op-code enum (names per REQ-015/018) and the FSM state enum.
REQ-032 The iterative multiply/divide datapath and FSM SHALL be a single sub-module, mdu_seq; the top level holds the combinational ops, output mux and Zero.
REQ-033 No memories and no vendor primitives; all registers SHALL use synchronous reset.

Verification (WIDTH=32)
REQ-034 SUB A=5, B=5 -> AluRes=0, Zero=1; SRA B=0x80000000, shamt=4 -> 0xF8000000; SLT A=0xFFFFFFFF, B=1 -> 1; SLTU with the same operands -> 0.
REQ-035 MULTU A=0xFFFFFFFF, B=0xFFFFFFFF, Start pulse -> Busy high 32 cycles, Done in cycle 33, Hi=0xFFFFFFFE, Lo=0x00000001.
REQ-036 DIVU A=100, B=7 -> Lo=14, Hi=2; DIVU A=9, B=0 -> Lo=0xFFFFFFFF, Hi=9.
REQ-037 MULTU 3*4 running, Start DIVU at cycle 10 -> ignored, Lo=12; MFLO at cycle 10 returns prior Lo.
REQ-038 Reset asserted at cycle 15 of DIVU -> no Done pulse, Hi=Lo=0, Busy=0 next cycle; new MULTU 2*3 afterwards -> Lo=6.
REQ-039 Back-to-back: MULTU, then Start DIVU in its DONE cycle -> second Done exactly 33 cycles after the first.
